// File: rtl/arm_pkg.sv
// Shared ARM definitions: condition codes, NZCV bit positions, flag merge helper.
package arm_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // sel[1] picks N,Z from upd; sel[0] picks C,V from upd.
  function automatic logic [3:0] merge_flags(input logic [3:0] base,
                                             input logic [1:0] sel,
                                             input logic [3:0] upd);
    logic [3:0] r;
    r = base;
    if (sel[1]) begin
      r[FLAG_N] = upd[FLAG_N];
      r[FLAG_Z] = upd[FLAG_Z];
    end
    if (sel[0]) begin
      r[FLAG_C] = upd[FLAG_C];
      r[FLAG_V] = upd[FLAG_V];
    end
    return r;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: cond field + NZCV -> pass.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      // NV is executed unconditionally on this core
      NV: pass = 1'b1;
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Holds NZCV, gates decoder write/branch requests by condition, counts executed/squashed instructions.
// Optional COND_FLAG_BYPASS_EN merges uncommitted later-stage flags into condition evaluation.
module cond_unit
  import arm_pkg::*;
#(
  parameter int         CNT_W    = 32,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic             CLK,
  input  logic             RESET_n,
  input  logic             InstrValid,
  input  logic             Stall,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
`ifdef COND_FLAG_BYPASS_EN
  input  logic             FwdValid,
  input  logic [1:0]       FwdFlagW,
  input  logic [3:0]       FwdFlags,
`endif
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic             C_Flag,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SquashCount
);

  logic [3:0]       flags_q;
  logic [3:0]       eval_flags;
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] squash_q;
  logic             pass;

`ifdef COND_FLAG_BYPASS_EN
  // Uncommitted flags from the later stage take precedence, per field
  assign eval_flags = merge_flags(flags_q, FwdValid ? FwdFlagW : 2'b00, FwdFlags);
`else
  assign eval_flags = flags_q;
`endif

  cond_check u_cond_check (
    .cond  (Cond),
    .flags (eval_flags),
    .pass  (pass)
  );

  assign CondEx   = pass & InstrValid;
  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & ~NoWrite & CondEx;
  assign MemWrite = MemW & CondEx;
  assign C_Flag   = eval_flags[FLAG_C];

  assign Flags       = flags_q;
  assign ExecCount   = exec_q;
  assign SquashCount = squash_q;

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      flags_q  <= FLAG_RST;
      exec_q   <= '0;
      squash_q <= '0;
    end else if (!Stall) begin
      if (CondEx) begin
        flags_q <= merge_flags(flags_q, FlagW, ALUFlags);
      end
      if (InstrValid) begin
        if (CondEx) exec_q   <= exec_q + CNT_W'(1);
        else        squash_q <= squash_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit (counter width reduced to exercise wrap).
module tb_cond_unit;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET_n, InstrValid, Stall, PCS, RegW, MemW, NoWrite;
  logic [3:0]    Cond, ALUFlags;
  logic [1:0]    FlagW;
  logic          PCSrc, RegWrite, MemWrite, CondEx, C_Flag;
  logic [3:0]    Flags;
  logic [CW-1:0] ExecCount, SquashCount;
`ifdef COND_FLAG_BYPASS_EN
  logic          FwdValid;
  logic [1:0]    FwdFlagW;
  logic [3:0]    FwdFlags;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  cond_unit #(.CNT_W(CW), .FLAG_RST(4'b0000)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .InstrValid(InstrValid), .Stall(Stall),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS),
    .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
`ifdef COND_FLAG_BYPASS_EN
    .FwdValid(FwdValid), .FwdFlagW(FwdFlagW), .FwdFlags(FwdFlags),
`endif
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .C_Flag(C_Flag), .Flags(Flags), .ExecCount(ExecCount), .SquashCount(SquashCount)
  );

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    InstrValid = 1'b0; Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
  endtask

  // Load NZCV through an AL instruction with FlagW=11
  task automatic set_flags(input logic [3:0] f);
    idle_inputs();
    InstrValid = 1'b1; FlagW = 2'b11; ALUFlags = f;
    tick();
    FlagW = 2'b00;
  endtask

  // Reference condition evaluation, written by predicate pairs
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n ~^ v);
      3'd6: base = !z && (n ~^ v);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return c[0] ? !base : base;
  endfunction

  initial begin
    vecs[0]  = '{4'b1010, 4'b1001, 1'b1};  // GE, N=1 V=1
    vecs[1]  = '{4'b1011, 4'b1001, 1'b0};  // LT, N=1 V=1
    vecs[2]  = '{4'b1100, 4'b0100, 1'b0};  // GT, Z=1
    vecs[3]  = '{4'b1111, 4'b0000, 1'b1};  // NV treated as always
    vecs[4]  = '{4'b1000, 4'b0010, 1'b1};  // HI
    vecs[5]  = '{4'b1000, 4'b0110, 1'b0};  // HI with Z
    vecs[6]  = '{4'b1001, 4'b0100, 1'b1};  // LS
    vecs[7]  = '{4'b1101, 4'b1000, 1'b1};  // LE, N!=V
    vecs[8]  = '{4'b0100, 4'b1000, 1'b1};  // MI
    vecs[9]  = '{4'b0111, 4'b0001, 1'b0};  // VC with V
    vecs[10] = '{4'b0001, 4'b0100, 1'b0};  // NE with Z
    vecs[11] = '{4'b0011, 4'b0000, 1'b1};  // CC
    vecs[12] = '{4'b0110, 4'b0001, 1'b1};  // VS
    vecs[13] = '{4'b0101, 4'b1111, 1'b0};  // PL with N
    vecs[14] = '{4'b1100, 4'b1001, 1'b1};  // GT, N=V Z=0
    vecs[15] = '{4'b1110, 4'b0000, 1'b1};  // AL

    // 1: reset with stall asserted
    idle_inputs();
    RESET_n = 1'b0; Stall = 1'b1;
`ifdef COND_FLAG_BYPASS_EN
    FwdValid = 1'b0; FwdFlagW = 2'b00; FwdFlags = 4'b0000;
`endif
    tick(); tick();
    check("rst_flags", 32'(Flags), 32'h0);
    check("rst_exec", 32'(ExecCount), 32'h0);
    check("rst_squash", 32'(SquashCount), 32'h0);
    check("rst_cflag", 32'(C_Flag), 32'h0);
    RESET_n = 1'b1; Stall = 1'b0;

    // 2: CMP then BEQ, taken and not taken
    idle_inputs();
    InstrValid = 1'b1; FlagW = 2'b11; NoWrite = 1'b1; RegW = 1'b1; ALUFlags = 4'b0110;
    #1 check("cmp_regwrite", 32'(RegWrite), 32'h0);
    check("cmp_condex", 32'(CondEx), 32'h1);
    tick();
    check("cmp_flags", 32'(Flags), 32'h6);
    idle_inputs();
    InstrValid = 1'b1; Cond = 4'b0000; PCS = 1'b1;
    #1 check("beq_taken", 32'(PCSrc), 32'h1);
    tick();
    idle_inputs();
    InstrValid = 1'b1; FlagW = 2'b11; NoWrite = 1'b1; ALUFlags = 4'b0010;
    tick();
    idle_inputs();
    InstrValid = 1'b1; Cond = 4'b0000; PCS = 1'b1;
    #1 check("beq_not_taken", 32'(PCSrc), 32'h0);
    check("cflag_held", 32'(C_Flag), 32'h1);
    tick();
    check("beq_squash", 32'(SquashCount), 32'h1);
    check("beq_exec", 32'(ExecCount), 32'h3);

    // 3: partial and null flag updates
    set_flags(4'b1111);
    idle_inputs();
    InstrValid = 1'b1; FlagW = 2'b10; ALUFlags = 4'b0000;
    tick();
    check("partial_nz", 32'(Flags), 32'h3);
    FlagW = 2'b00; ALUFlags = 4'b1100;
    tick();
    check("flagw00_hold", 32'(Flags), 32'h3);
    FlagW = 2'b01; ALUFlags = 4'b1110;
    tick();
    check("partial_cv", 32'(Flags), 32'h2);

    // 4: squashed MOVSEQ-style instruction
    set_flags(4'b0000);
    idle_inputs();
    InstrValid = 1'b1; Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111;
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
    #1 check("sq_condex", 32'(CondEx), 32'h0);
    check("sq_gates", 32'({PCSrc, RegWrite, MemWrite}), 32'h0);
    tick();
    check("sq_flags", 32'(Flags), 32'h0);
    check("sq_count", 32'(SquashCount), 32'h2);
    idle_inputs();
    RegW = 1'b1; MemW = 1'b1;
    #1 check("bubble_gates", 32'({CondEx, RegWrite, MemWrite}), 32'h0);

    // 5: directed table, then full sweep
    for (int i = 0; i < 16; i++) begin
      set_flags(vecs[i].flags);
      idle_inputs();
      InstrValid = 1'b1; Cond = vecs[i].cond;
      #1 check($sformatf("vec%0d_cond%b_flags%b", i, vecs[i].cond, vecs[i].flags),
               32'(CondEx), 32'(vecs[i].exp));
    end
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      idle_inputs();
      InstrValid = 1'b1;
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #1 check($sformatf("sweep_cond%0h_flags%0h", c, f), 32'(CondEx), 32'(ref_pass(4'(c), 4'(f))));
      end
    end

    // 6: reset beats a pending update, stall freezes, counter wrap
    idle_inputs();
    RESET_n = 1'b0; InstrValid = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
    tick();
    check("rst_discard_flags", 32'(Flags), 32'h0);
    check("rst_discard_exec", 32'(ExecCount), 32'h0);
    RESET_n = 1'b1; Stall = 1'b1;
    #1 check("stall_condex", 32'(CondEx), 32'h1);
    tick();
    check("stall_flags", 32'(Flags), 32'h0);
    check("stall_exec", 32'(ExecCount), 32'h0);
    Stall = 1'b0; FlagW = 2'b00;
    for (int i = 0; i < 15; i++) tick();
    check("exec_max", 32'(ExecCount), 32'hF);
    tick();
    check("exec_wrap", 32'(ExecCount), 32'h0);
    check("wrap_squash", 32'(SquashCount), 32'h0);
    InstrValid = 1'b0;
    tick();
    check("invalid_nochange", 32'({ExecCount, SquashCount}), 32'h0);

`ifdef COND_FLAG_BYPASS_EN
    idle_inputs();
    InstrValid = 1'b1; Cond = 4'b0000;
    FwdValid = 1'b1; FwdFlagW = 2'b11; FwdFlags = 4'b0110;
    #1 check("byp_eq", 32'(CondEx), 32'h1);
    check("byp_cflag", 32'(C_Flag), 32'h1);
    FwdFlagW = 2'b01;
    #1 check("byp_cv_only", 32'(CondEx), 32'h0);
    FwdValid = 1'b0; FwdFlagW = 2'b11;
    #1 check("byp_invalid", 32'(CondEx), 32'h0);
    FwdValid = 1'b1; Cond = 4'b1110;
    tick();
    check("byp_reg_unchanged", 32'(Flags), 32'h0);
    FwdValid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
